// File: rtl/turbo_sched.sv
// turbo_sched: effective CPU turbo mode scheduler.
// Applies turbo_req only at M1 fetch boundaries while INT is idle.
// With TURBO_AUTOSLOW_EN defined, sound/tape port activity forces
// a temporary slowdown to 3.5 MHz for HOLD_LEN+1 clkcpu edges.
//
// Ports:
//   rst_n           async active-low reset
//   clkcpu          CPU clock, state updates on rising edge
//   turbo_req       requested mode (2'd0 NONE, 2'd1 7, 2'd2 14, 2'd3 28)
//   machine         current machine type (port decode is identical)
//   n_int           CPU INT line, active-low
//   m1/mreq/iorq    decoded CPU strobes, active-high
//   rd/wr           decoded CPU strobes, active-high
//   a               CPU address bus
//   rom_wait_en     enables ROM wait-state requests
//   turbo           effective turbo mode
//   ext_wait_cycle1 first extra wait request in TURBO_14
//   ext_wait_cycle2 second extra wait request in TURBO_14
//   slow_active     forced slowdown in effect
//
// Macro: TURBO_AUTOSLOW_EN compiles in triggers, SLOW state and hold.

module turbo_sched #(
    parameter int unsigned       HOLD_W   = 14,
    parameter logic [HOLD_W-1:0] HOLD_LEN = {HOLD_W{1'b1}}
) (
    input  logic        rst_n,
    input  logic        clkcpu,
    input  logic [1:0]  turbo_req,
    input  logic [2:0]  machine,
    input  logic        n_int,
    input  logic        m1,
    input  logic        mreq,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] a,
    input  logic        rom_wait_en,
    output logic [1:0]  turbo,
    output logic        ext_wait_cycle1,
    output logic        ext_wait_cycle2,
    output logic        slow_active
);

    localparam logic [1:0] TURBO_NONE = 2'd0;
    localparam logic [1:0] TURBO_14   = 2'd2;

    logic       r_m1_prev;
    logic [1:0] r_turbo;
    logic       w_bnd;
    logic       w_t14;
    logic       w_ula_io;
    logic       w_unused;

    // Machine type does not alter port decoding; Pentagon counts
    // the same as the other machines.
    assign w_unused = &{1'b0, machine, a, rd, wr, HOLD_LEN};

    // Opcode fetch start, held off while INT is asserted.
    assign w_bnd = m1 & mreq & ~r_m1_prev & n_int;

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_m1_prev <= 1'b0;
        end else begin
            r_m1_prev <= m1;
        end
    end

`ifdef TURBO_AUTOSLOW_EN

    typedef enum logic {
        S_RUN  = 1'b0,
        S_SLOW = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic              w_ay;
    logic              w_ula;
    logic              w_trig;
    logic              w_slow;

    assign w_ay   = iorq & a[15] & ~a[1] & (rd | wr);
    assign w_ula  = iorq & ~a[0] & wr;
    assign w_trig = (turbo_req != TURBO_NONE) & (w_ay | w_ula);

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN: begin
                if (w_trig) begin
                    w_state_nxt = S_SLOW;
                end
            end
            S_SLOW: begin
                if (!w_trig && r_hold == '0) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_slow = (r_state == S_SLOW);
    end

    assign slow_active = w_slow;

    // Reload wins over the saturating decrement.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_trig) begin
            r_hold <= HOLD_LEN;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_ONE;
        end
    end

    // A trigger on a boundary edge in RUN already forces NONE.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_turbo <= TURBO_NONE;
        end else if (w_bnd) begin
            r_turbo <= (w_slow | w_trig) ? TURBO_NONE : turbo_req;
        end
    end

`else

    assign slow_active = 1'b0;

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_turbo <= TURBO_NONE;
        end else if (w_bnd) begin
            r_turbo <= turbo_req;
        end
    end

`endif

    assign turbo = r_turbo;

    assign w_t14    = (r_turbo == TURBO_14);
    assign w_ula_io = iorq & ~a[0];

    assign ext_wait_cycle1 = w_t14 &
        ((mreq & (a[15:14] == 2'b00) & rom_wait_en) | w_ula_io);
    assign ext_wait_cycle2 = w_t14 & w_ula_io;

endmodule

// File: tb/tb_turbo_sched.sv
// tb_turbo_sched: self-checking bench for turbo_sched.
// Directed scenarios plus a randomized run against a reference model.

module tb_turbo_sched;

`ifdef TURBO_AUTOSLOW_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int HLEN = 15;

    logic        rst_n;
    logic        clkcpu;
    logic [1:0]  turbo_req;
    logic [2:0]  machine;
    logic        n_int;
    logic        m1;
    logic        mreq;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic        rom_wait_en;
    logic [1:0]  turbo;
    logic        ext_wait_cycle1;
    logic        ext_wait_cycle2;
    logic        slow_active;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [1:0] m_turbo;
    bit         m_m1_prev;
    int         m_cycle;
    int         m_last;

    turbo_sched #(
        .HOLD_W   (4),
        .HOLD_LEN (4'd15)
    ) dut (
        .rst_n           (rst_n),
        .clkcpu          (clkcpu),
        .turbo_req       (turbo_req),
        .machine         (machine),
        .n_int           (n_int),
        .m1              (m1),
        .mreq            (mreq),
        .iorq            (iorq),
        .rd              (rd),
        .wr              (wr),
        .a               (a),
        .rom_wait_en     (rom_wait_en),
        .turbo           (turbo),
        .ext_wait_cycle1 (ext_wait_cycle1),
        .ext_wait_cycle2 (ext_wait_cycle2),
        .slow_active     (slow_active)
    );

    initial begin
        clkcpu = 1'b0;
        forever #5 clkcpu = ~clkcpu;
    end

    // Slowdown holds while the last trigger is at most HLEN edges old.
    function automatic bit m_slow();
        return AUTO && ((m_cycle - m_last) <= HLEN);
    endfunction

    function automatic bit m_trig();
        bit ay;
        bit ula;
        ay  = iorq && a[15] && !a[1] && (rd || wr);
        ula = iorq && !a[0] && wr;
        return AUTO && (turbo_req != 2'd0) && (ay || ula);
    endfunction

    function automatic bit m_w1();
        bit rom;
        rom = mreq && (a[15:14] == 2'b00) && rom_wait_en;
        return (m_turbo == 2'd2) && (rom || (iorq && !a[0]));
    endfunction

    function automatic bit m_w2();
        return (m_turbo == 2'd2) && iorq && !a[0];
    endfunction

    task automatic model_reset();
        m_turbo   = 2'd0;
        m_m1_prev = 1'b0;
        m_last    = -1000;
    endtask

    // One clkcpu edge; model advances with the inputs held over it.
    task automatic tick();
        bit pre;
        bit trg;
        bit bnd;
        pre = m_slow();
        trg = m_trig();
        bnd = m1 && mreq && !m_m1_prev && n_int;
        if (bnd) m_turbo = (pre || trg) ? 2'd0 : turbo_req;
        m_m1_prev = m1;
        m_cycle++;
        if (trg) m_last = m_cycle;
        @(posedge clkcpu);
        #1;
    endtask

    task automatic set_idle();
        m1   = 1'b0;
        mreq = 1'b0;
        iorq = 1'b0;
        rd   = 1'b0;
        wr   = 1'b0;
        a    = 16'h4000;
    endtask

    task automatic fetch();
        set_idle();
        tick();
        m1   = 1'b1;
        mreq = 1'b1;
        tick();
        set_idle();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        turbo_req   = 2'd2;
        machine     = 3'd0;
        n_int       = 1'b1;
        rom_wait_en = 1'b1;
        set_idle();
        mreq = 1'b1;
        a    = 16'h0038;
        m_cycle = 0;
        model_reset();
        #1;
        n_total++;
        if (turbo !== 2'd0)
            $display("FAIL rst_turbo got %0d want 0", turbo);
        else n_pass++;
        n_total++;
        if (slow_active !== 1'b0)
            $display("FAIL rst_slow got %0d want 0", slow_active);
        else n_pass++;
        n_total++;
        if (ext_wait_cycle1 !== 1'b0)
            $display("FAIL rst_w1 got %0d want 0", ext_wait_cycle1);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        set_idle();
        repeat (3) tick();
        n_total++;
        if (turbo !== 2'd0)
            $display("FAIL rst_idle got %0d want 0", turbo);
        else n_pass++;
        m1   = 1'b1;
        mreq = 1'b1;
        tick();
        n_total++;
        if (turbo !== 2'd2)
            $display("FAIL rst_first_m1 got %0d want 2", turbo);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_int_block();
        turbo_req = 2'd1;
        fetch();
        n_total++;
        if (turbo !== 2'd1)
            $display("FAIL int_t7 got %0d want 1", turbo);
        else n_pass++;
        turbo_req = 2'd2;
        n_int = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fetch();
            n_total++;
            if (turbo !== 2'd1)
                $display("FAIL int_hold%0d got %0d want 1", i, turbo);
            else n_pass++;
        end
        n_int = 1'b1;
        fetch();
        n_total++;
        if (turbo !== 2'd2)
            $display("FAIL int_release got %0d want 2", turbo);
        else n_pass++;
    endtask

    task automatic test_slowdown();
        turbo_req = 2'd2;
        fetch();
        iorq = 1'b1;
        wr   = 1'b1;
        a    = 16'hFFFD;
        tick();
        set_idle();
        n_total++;
        if (slow_active !== 1'b1)
            $display("FAIL slow_rise got %0d want 1", slow_active);
        else n_pass++;
        n_total++;
        if (turbo !== 2'd2)
            $display("FAIL slow_no_bnd got %0d want 2", turbo);
        else n_pass++;
        m1   = 1'b1;
        mreq = 1'b1;
        tick();
        set_idle();
        n_total++;
        if (turbo !== 2'd0)
            $display("FAIL slow_bnd got %0d want 0", turbo);
        else n_pass++;
        repeat (HLEN - 1) tick();
        n_total++;
        if (slow_active !== 1'b1)
            $display("FAIL slow_hold got %0d want 1", slow_active);
        else n_pass++;
        tick();
        n_total++;
        if (slow_active !== 1'b0)
            $display("FAIL slow_fall got %0d want 0", slow_active);
        else n_pass++;
        n_total++;
        if (turbo !== 2'd0)
            $display("FAIL slow_exit_t got %0d want 0", turbo);
        else n_pass++;
        fetch();
        n_total++;
        if (turbo !== 2'd2)
            $display("FAIL slow_back got %0d want 2", turbo);
        else n_pass++;
    endtask

    task automatic test_reload();
        turbo_req = 2'd2;
        iorq = 1'b1;
        wr   = 1'b1;
        a    = 16'h00FE;
        tick();
        set_idle();
        repeat (10) tick();
        iorq = 1'b1;
        wr   = 1'b1;
        a    = 16'h00FE;
        tick();
        set_idle();
        repeat (HLEN) tick();
        n_total++;
        if (slow_active !== 1'b1)
            $display("FAIL reload_hold got %0d want 1", slow_active);
        else n_pass++;
        tick();
        n_total++;
        if (slow_active !== 1'b0)
            $display("FAIL reload_fall got %0d want 0", slow_active);
        else n_pass++;
        fetch();
        n_total++;
        if (turbo !== 2'd2)
            $display("FAIL reload_back got %0d want 2", turbo);
        else n_pass++;
    endtask

    task automatic test_no_autoslow();
        turbo_req = 2'd2;
        fetch();
        iorq = 1'b1;
        wr   = 1'b1;
        a    = 16'hFFFD;
        tick();
        set_idle();
        n_total++;
        if (slow_active !== 1'b0)
            $display("FAIL noslow_flag got %0d want 0", slow_active);
        else n_pass++;
        fetch();
        n_total++;
        if (turbo !== 2'd2)
            $display("FAIL noslow_turbo got %0d want 2", turbo);
        else n_pass++;
    endtask

    task automatic test_wait();
        turbo_req   = 2'd2;
        rom_wait_en = 1'b1;
        fetch();
        mreq = 1'b1;
        a    = 16'h0038;
        #1;
        n_total++;
        if (ext_wait_cycle1 !== 1'b1)
            $display("FAIL wait_rom_w1 got %0d want 1", ext_wait_cycle1);
        else n_pass++;
        n_total++;
        if (ext_wait_cycle2 !== 1'b0)
            $display("FAIL wait_rom_w2 got %0d want 0", ext_wait_cycle2);
        else n_pass++;
        set_idle();
        iorq = 1'b1;
        rd   = 1'b1;
        a    = 16'h00FE;
        #1;
        n_total++;
        if (ext_wait_cycle1 !== 1'b1)
            $display("FAIL wait_in_w1 got %0d want 1", ext_wait_cycle1);
        else n_pass++;
        n_total++;
        if (ext_wait_cycle2 !== 1'b1)
            $display("FAIL wait_in_w2 got %0d want 1", ext_wait_cycle2);
        else n_pass++;
        set_idle();
        turbo_req = 2'd1;
        fetch();
        iorq = 1'b1;
        rd   = 1'b1;
        a    = 16'h00FE;
        #1;
        n_total++;
        if ({ext_wait_cycle1, ext_wait_cycle2} !== 2'b00)
            $display("FAIL wait_t7 got %b want 00",
                     {ext_wait_cycle1, ext_wait_cycle2});
        else n_pass++;
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(249) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                n_total++;
                if (turbo !== 2'd0 || slow_active !== 1'b0)
                    $display("FAIL rnd_rst%0d got %0d/%0d want 0/0",
                             i, turbo, slow_active);
                else n_pass++;
                rst_n = 1'b1;
            end
            if ($urandom_range(7) == 0)
                turbo_req = 2'($urandom_range(3));
            machine     = 3'($urandom_range(7));
            n_int       = ($urandom_range(4) != 0);
            rom_wait_en = 1'($urandom_range(1));
            m1   = ($urandom_range(2) == 0);
            mreq = m1 ? 1'b1 : 1'($urandom_range(1));
            iorq = !mreq && ($urandom_range(15) == 0);
            rd   = 1'($urandom_range(1));
            wr   = !rd && ($urandom_range(1) == 1);
            case ($urandom_range(3))
                0:       a = 16'hFFFD;
                1:       a = 16'h00FE;
                2:       a = 16'h0038;
                default: a = 16'($urandom);
            endcase
            tick();
            n_total++;
            if (turbo !== m_turbo)
                $display("FAIL rnd_turbo%0d got %0d want %0d",
                         i, turbo, m_turbo);
            else n_pass++;
            n_total++;
            if (slow_active !== m_slow())
                $display("FAIL rnd_slow%0d got %0d want %0d",
                         i, slow_active, m_slow());
            else n_pass++;
            n_total++;
            if (ext_wait_cycle1 !== m_w1())
                $display("FAIL rnd_w1_%0d got %0d want %0d",
                         i, ext_wait_cycle1, m_w1());
            else n_pass++;
            n_total++;
            if (ext_wait_cycle2 !== m_w2())
                $display("FAIL rnd_w2_%0d got %0d want %0d",
                         i, ext_wait_cycle2, m_w2());
            else n_pass++;
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_int_block();
`ifdef TURBO_AUTOSLOW_EN
        test_slowdown();
        test_reload();
`else
        test_no_autoslow();
`endif
        test_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/turbo_sched.md
# turbo_sched

CPU speed scheduler that sits between the configuration registers and the clock/contention controller. It takes the requested turbo mode and produces the effective `turbo` value consumed by the clock generator. Mode changes are applied only at opcode-fetch (M1) boundaries and never while INT is asserted. A temporary forced slowdown to 3.5 MHz is applied after sound/tape port activity, and the block supplies the `ext_wait_cycle1/2` wait-state requests used in TURBO_14.

## Interface
Parameters:
- `HOLD_W`, 14: width of the slowdown hold counter.
- `HOLD_LEN`, 2**HOLD_W-1: value loaded into the hold counter on each slowdown trigger.

Ports:
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clkcpu`  in  1  CPU clock; all state is updated on its rising edge.
- `turbo_req`  in  turbo_t  requested mode from the configuration register.
- `machine`  in  machine_t  current machine type.
- `n_int`  in  1  CPU INT line, active-low.
- `m1`, `mreq`, `iorq`, `rd`, `wr`  in  1 each  decoded CPU strobes, active-high.
- `a`  in  16  CPU address bus.
- `rom_wait_en`  in  1  enables ROM wait-state requests.
- `turbo`  out  turbo_t  effective turbo mode.
- `ext_wait_cycle1`  out  1  request for one extra wait in TURBO_14.
- `ext_wait_cycle2`  out  1  request for a second extra wait in TURBO_14.
- `slow_active`  out  1  high while a forced slowdown is in effect.

## Operation
- **M1 boundary:** `bnd = m1 && mreq && !m1_prev`. `m1_prev` is registered on every `clkcpu` edge. `bnd` is suppressed while `n_int == 0`.
- **State machine** with two states, RUN and SLOW:
  - **RUN:** at `bnd`, `turbo <= turbo_req`. When a trigger occurs, go to SLOW, load `hold <= HOLD_LEN`, and set `slow_active <= 1`. `turbo` changes to TURBO_NONE at the next `bnd`, not immediately.
  - **SLOW:** at `bnd`, `turbo <= TURBO_NONE`. `hold` decrements by 1 on each edge, saturating at 0. A new trigger reloads `HOLD_LEN`.
  - **SLOW exit:** when `hold == 0` and there is no trigger, go to RUN and set `slow_active <= 0`. `turbo_req` is applied at the next `bnd`.
- **Triggers** (only when `turbo_req != TURBO_NONE`):
  - AY access: `iorq && a[15] && !a[1] && (rd || wr)`.
  - ULA port write: `iorq && !a[0] && wr`.
  - Triggers from machine MACHINE_PENT count identically.
- **Combinational wait outputs**, active only when `turbo == TURBO_14`:
  - `ext_wait_cycle1 = (mreq && a[15:14] == 2'b00 && rom_wait_en) || (iorq && !a[0])`.
  - `ext_wait_cycle2 = iorq && !a[0]`.
- **Arithmetic:** `hold` is an unsigned `HOLD_W`-bit counter. Reload takes priority over decrement. There is no wrap-around; the counter saturates at 0.

## Timing
- **Reset values:**
  - `turbo` = TURBO_NONE
  - state = RUN
  - `hold` = 0
  - `slow_active` = 0
  - `m1_prev` = 0
  - `ext_wait_cycle*` follow from `turbo` = TURBO_NONE, so they are 0.
- **Latency:**
  - `turbo_req` change → `turbo`: at the first `bnd` edge after the change, registered at that edge.
  - Trigger → `slow_active`: 1 `clkcpu` edge.
  - Trigger → `turbo` = TURBO_NONE: at the next `bnd`.
- `slow_active` falls exactly `HOLD_LEN + 1` edges after the last trigger edge.
- **Simultaneous events:**
  - Trigger on the same edge as `hold == 1→0`: stays in SLOW and reloads.
  - Trigger on a `bnd` edge while in RUN: `turbo` takes TURBO_NONE on that same edge.
  - `turbo_req` changes while in SLOW: only the last value is applied after exit.
- `n_int` low across several M1 cycles holds `turbo` unchanged. The first `bnd` after `n_int` rises applies the pending value.
- **Reset mid-slowdown:** all state clears at once, and `turbo_req` is applied at the first `bnd` after release.
- `clkcpu` may be stretched by waits. There is no timing dependence other than the edge count.

## Configuration
- `TURBO_AUTOSLOW_EN`:
  - **Defined:** trigger detection, the SLOW state and the `hold` counter are compiled in.
  - **Undefined:** the block is RUN-only, `slow_active` is tied to 0, and `turbo` follows `turbo_req` at M1 boundaries. Wait outputs are unchanged.

## Test plan
- Reset with `turbo_req` = TURBO_14 → `turbo` = TURBO_NONE until the first M1 rising edge, then TURBO_14 on that edge.
- `turbo_req` TURBO_7→TURBO_14 mid-instruction with `n_int` = 0 over two M1 fetches → `turbo` stays TURBO_7; it becomes TURBO_14 at the first M1 after `n_int` rises.
- `HOLD_LEN` = 15, `turbo_req` = TURBO_14, OUT (#FFFD) → `slow_active` is 1 the next edge, `turbo` = TURBO_NONE at the next M1, `slow_active` falls 16 edges later, and TURBO_14 returns at the following M1.
- Second OUT (#FE) 10 edges into the hold → counter reloads, and `slow_active` stays high 16 edges from the second trigger.
- `turbo` = TURBO_14, `rom_wait_en` = 1, mreq at #0038 → `ext_wait_cycle1` = 1, `ext_wait_cycle2` = 0. IN (#FE) → both outputs 1. At TURBO_7 → both outputs 0.
- Build without `TURBO_AUTOSLOW_EN`, OUT (#FFFD) at TURBO_14 → `slow_active` = 0 and `turbo` remains TURBO_14.
